mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single SRAM-like CPU memory bus between the instruction-fetch requester and the MEM-stage data requester. The MEM-stage IO controller supplies the data request, already qualified by exceptions. Requests are serialised through a small FSM that handles the bus address/data handshake. Each requester gets a registered read-data return with a one-cycle valid pulse, plus a stall indication for the pipeline controller.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width

Ports:
- clk_i  in  1  clock; everything sampled on rising edge
- rst_i  in  1  reset, synchronous, active-low
- inst_req_i  in  1  fetch request, level, held until inst_valid_o
- inst_addr_i  in  ADDR_W  fetch address
- inst_rdata_o  out  DATA_W  fetched word (registered)
- inst_valid_o  out  1  one-cycle pulse: inst_rdata_o valid
- flush_i  in  1  discard result of any pending/in-flight fetch
- data_req_i  in  1  MEM request, level, held until data_valid_o
- data_wr_i  in  1  1 = store, 0 = load
- data_sel_i  in  4  byte enables
- data_addr_i  in  ADDR_W  data address
- data_wdata_i  in  DATA_W  store data
- data_rdata_o  out  DATA_W  load data (registered)
- data_valid_o  out  1  one-cycle pulse: load data returned or store completed
- stall_o  out  1  pipeline must hold
- bus_req_o  out  1  bus request
- bus_wr_o  out  1  bus write
- bus_size_o  out  2  0 = byte, 1 = half, 2 = word
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_addr_ok_i  in  1  address accepted
- bus_data_ok_i  in  1  data returned or write done
- bus_rdata_i  in  DATA_W  bus read data

## Operation
- FSM states: IDLE, ADDR, WAIT.
- **IDLE:**
  - Grant data if data_req_i. Else grant inst if inst_req_i (fixed data priority).
  - Grant latches owner, wr, size, addr and wdata into registers. Next state is ADDR.
  - A requester is not granted in a cycle where its own valid_o is high. This prevents re-issuing a request still held high.
  - A fetch is not granted while flush_i is high.
- **ADDR:**
  - bus_req_o = 1, driven from the latched fields. Fields are stable until accepted.
  - On bus_addr_ok_i go to WAIT.
- **WAIT:**
  - bus_req_o = 0.
  - On bus_data_ok_i, register bus_rdata_i into the owner's rdata_o. Pulse the owner's valid_o next cycle. Go to IDLE.
- **Size decode:**
  - 1111 → 2
  - 0011/1100 → 1
  - one-hot → 0
  - any other pattern → 2
  - Address passes through unmodified.
- **Flush:**
  - flush_i during ADDR or WAIT with owner = inst sets drop_q. The bus transaction always completes, with no withdrawal.
  - On completion inst_valid_o is suppressed and inst_rdata_o is not updated. drop_q clears on return to IDLE.
  - Data transactions ignore flush_i. Exception cancellation is done upstream.
- **stall_o** = (inst_req_i & ~inst_valid_o & ~flush_i) | (data_req_i & ~data_valid_o).
- **Reset (rst_i = 0 at edge), from any state:**
  - State → IDLE; bus_req_o, bus_wr_o, valid pulses, drop_q = 0.
  - bus_size_o = 0, addresses/data = 0, rdata_o = 0.
  - An in-flight bus transaction is abandoned. Bus-side recovery is the bus owner's responsibility.

## Timing
- Minimum latency, request to valid: 3 cycles.
  - Cycle 0: IDLE grant.
  - Cycle 1: ADDR, with addr_ok.
  - Cycle 2: WAIT, with data_ok.
  - Cycle 3: valid.
- Each additional cycle without addr_ok or data_ok adds one cycle.
- Back-to-back transactions: a new grant is possible in the valid cycle, for the other requester only. Bus throughput is one transaction per 3 cycles minimum.
- bus_* outputs are registered, with no combinational path from *_req_i.
- stall_o is combinational.
- Simultaneous data_req_i and inst_req_i in IDLE: data wins. The fetch waits, with stall_o held.
- addr_ok and data_ok in the same cycle while in ADDR: data_ok is ignored. It is only valid in WAIT, since the bus returns data no earlier than the cycle after addr_ok.

## Structure
- Package mem_arb_pkg: state enum (IDLE/ADDR/WAIT), owner enum (OWN_INST/OWN_DATA), size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module, mem_sel_to_size: combinational sel → size decoder, reused by the uncached path later.

## Test plan
- Single fetch at 0xBFC00000, addr_ok/data_ok immediate, rdata 0x3C08BFC0 → inst_valid_o at cycle 3 with that word; stall_o high cycles 0–2.
- data_req_i store (sel 1100, addr 0x80000002, wdata 0x12340000) together with inst_req_i → data bus first (size 1, wr 1); fetch issued in data_valid_o cycle; inst_valid_o 3 cycles later.
- Fetch with addr_ok delayed 4 cycles → bus_req_o and bus_addr_o stable all 4 cycles; valid 7 cycles after request.
- flush_i pulsed in WAIT of fetch → bus completes, no inst_valid_o, inst_rdata_o unchanged; next fetch proceeds normally.
- Requester holds req through valid cycle, drops next cycle → exactly one bus transaction per request.
- rst_i low during WAIT → next cycle IDLE, all outputs at reset values, no valid pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU memory-bus arbiter: FSM state, bus owner, transfer size codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_sel_to_size.sv
// Byte-enable to bus transfer size decoder; irregular enable patterns fall back to a word access.
module mem_sel_to_size
    import mem_arb_pkg::*;
(
    input  logic [3:0] sel_i,
    output logic [1:0] size_o
);

    always_comb begin
        case (sel_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SZ_BYTE;
            4'b0011, 4'b1100:                   size_o = SZ_HALF;
            default:                            size_o = SZ_WORD;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction-fetch and MEM-stage data requests onto one SRAM-like bus,
// returning registered read data with a one-cycle valid pulse per requester.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_valid_o,
    input  logic              flush_i,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [3:0]        data_sel_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_valid_o,
    output logic              stall_o,
    output logic              bus_req_o,
    output logic              bus_wr_o,
    output logic [1:0]        bus_size_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_addr_ok_i,
    input  logic              bus_data_ok_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              drop_q, drop_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_wr_q, bus_wr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              inst_valid_q, inst_valid_d;
    logic              data_valid_q, data_valid_d;

    logic [1:0] data_size;
    logic       grant_data, grant_inst, flush_inst;

    mem_sel_to_size u_sel_to_size (
        .sel_i  (data_sel_i),
        .size_o (data_size)
    );

    // A requester whose valid is up is still holding its old request; skip it this cycle.
    assign grant_data = data_req_i & ~data_valid_q;
    assign grant_inst = inst_req_i & ~inst_valid_q & ~flush_i & ~grant_data;
    assign flush_inst = flush_i & (owner_q == OWN_INST);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_valid_d = 1'b0;
        data_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = ADDR;
                    owner_d     = OWN_DATA;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_wr_i;
                    bus_size_d  = data_size;
                    bus_addr_d  = data_addr_i;
                    bus_wdata_d = data_wdata_i;
                end else if (grant_inst) begin
                    state_d     = ADDR;
                    owner_d     = OWN_INST;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = 1'b0;
                    bus_size_d  = SZ_WORD;
                    bus_addr_d  = inst_addr_i;
                    bus_wdata_d = '0;
                end
            end
            ADDR: begin
                drop_d = drop_q | flush_inst;
                if (bus_addr_ok_i) begin
                    state_d   = WAIT;
                    bus_req_d = 1'b0;
                end
            end
            WAIT: begin
                drop_d = drop_q | flush_inst;
                if (bus_data_ok_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (owner_q == OWN_DATA) begin
                        data_rdata_d = bus_rdata_i;
                        data_valid_d = 1'b1;
                    end else if (!(drop_q | flush_i)) begin
                        inst_rdata_d = bus_rdata_i;
                        inst_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            drop_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= SZ_BYTE;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_valid_q <= inst_valid_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign inst_rdata_o = inst_rdata_q;
    assign inst_valid_o = inst_valid_q;
    assign data_rdata_o = data_rdata_q;
    assign data_valid_o = data_valid_q;
    assign bus_req_o    = bus_req_q;
    assign bus_wr_o     = bus_wr_q;
    assign bus_size_o   = bus_size_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign stall_o      = (inst_req_i & ~inst_valid_q & ~flush_i) | (data_req_i & ~data_valid_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomised dual-requester traffic
// against a transaction-level bus slave and read-data model.
module tb_mem_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_req_i, flush_i, data_req_i, data_wr_i;
    logic [31:0] inst_addr_i, data_addr_i, data_wdata_i;
    logic [3:0]  data_sel_i;
    logic [31:0] inst_rdata_o, data_rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic        inst_valid_o, data_valid_o, stall_o, bus_req_o, bus_wr_o;
    logic [1:0]  bus_size_o;
    logic        bus_addr_ok_i, bus_data_ok_i;

    int errs = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;
    txn_t bus_log[$];

    int a_dly = 0;
    int d_dly = 0;
    bit rand_dly = 1'b0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_rdata_o(inst_rdata_o), .inst_valid_o(inst_valid_o),
        .flush_i(flush_i),
        .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_sel_i(data_sel_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_valid_o(data_valid_o),
        .stall_o(stall_o),
        .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_size_o(bus_size_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Read-data model: boot vector is fixed, everything else is a scramble of the address.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_BFC0;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [1:0] exp_size(input logic [3:0] sel);
        if ($countones(sel) == 1) return 2'd0;
        if (sel == 4'b0011 || sel == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Bus slave: accepts after a_dly idle request cycles, answers d_dly cycles into WAIT.
    initial begin : slave
        int sst;
        int cnt;
        logic [31:0] pend_addr;
        logic pend_wr;
        txn_t t;
        sst = 0; cnt = 0; pend_addr = '0; pend_wr = 1'b0;
        bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            bus_addr_ok_i = 1'b0;
            bus_data_ok_i = 1'b0;
            if (!rst_i) begin
                sst = 0;
            end else if (sst == 2) begin
                if (cnt == 0) begin
                    bus_data_ok_i = 1'b1;
                    bus_rdata_i = pend_wr ? $urandom : rd(pend_addr);
                    sst = 0;
                end else cnt--;
            end else if (bus_req_o) begin
                if (sst == 0) begin
                    sst = 1;
                    cnt = rand_dly ? int'($urandom_range(0, 3)) : a_dly;
                end
                if (cnt == 0) begin
                    bus_addr_ok_i = 1'b1;
                    t.addr = bus_addr_o; t.wr = bus_wr_o; t.size = bus_size_o; t.wdata = bus_wdata_o;
                    bus_log.push_back(t);
                    pend_addr = bus_addr_o;
                    pend_wr = bus_wr_o;
                    sst = 2;
                    cnt = rand_dly ? int'($urandom_range(0, 3)) : d_dly;
                end else cnt--;
            end
        end
    end

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) tick();
        checks++; if ({bus_req_o, bus_wr_o, bus_size_o} !== 4'b0) begin errs++; $display("FAIL reset_bus_ctl: got %b want 0000", {bus_req_o, bus_wr_o, bus_size_o}); end
        checks++; if ({bus_addr_o, bus_wdata_o} !== 64'h0) begin errs++; $display("FAIL reset_bus_addr_data: got %h want 0", {bus_addr_o, bus_wdata_o}); end
        checks++; if ({inst_rdata_o, data_rdata_o} !== 64'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", {inst_rdata_o, data_rdata_o}); end
        checks++; if ({inst_valid_o, data_valid_o, stall_o} !== 3'b0) begin errs++; $display("FAIL reset_valid_stall: got %b want 000", {inst_valid_o, data_valid_o, stall_o}); end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        int n0;
        n0 = bus_log.size();
        inst_addr_i = 32'hBFC0_0000; inst_req_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b1) begin errs++; $display("FAIL fetch_stall_c0: got %b want 1", stall_o); end
        tick();
        checks++; if ({bus_req_o, bus_wr_o, bus_size_o, bus_addr_o} !== {1'b1, 1'b0, 2'd2, 32'hBFC0_0000}) begin
            errs++; $display("FAIL fetch_bus_c1: got req=%b wr=%b sz=%0d addr=%h want 1 0 2 bfc00000", bus_req_o, bus_wr_o, bus_size_o, bus_addr_o); end
        checks++; if ({stall_o, inst_valid_o} !== 2'b10) begin errs++; $display("FAIL fetch_c1_stall_valid: got %b want 10", {stall_o, inst_valid_o}); end
        tick();
        checks++; if ({bus_req_o, stall_o, inst_valid_o} !== 3'b010) begin errs++; $display("FAIL fetch_c2: got %b want 010", {bus_req_o, stall_o, inst_valid_o}); end
        tick();
        checks++; if (inst_valid_o !== 1'b1 || inst_rdata_o !== 32'h3C08_BFC0) begin
            errs++; $display("FAIL fetch_c3_data: got v=%b d=%h want 1 3c08bfc0", inst_valid_o, inst_rdata_o); end
        checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL fetch_c3_stall: got %b want 0", stall_o); end
        tick();
        inst_req_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL fetch_pulse_len: got %b want 0", inst_valid_o); end
        tick();
        checks++; if (bus_req_o !== 1'b0 || bus_log.size() != n0 + 1) begin
            errs++; $display("FAIL fetch_single_txn: got req=%b txns=%0d want 0 %0d", bus_req_o, bus_log.size() - n0, 1); end
    endtask

    task automatic test_priority();
        data_req_i = 1'b1; data_wr_i = 1'b1; data_sel_i = 4'b1100;
        data_addr_i = 32'h8000_0002; data_wdata_i = 32'h1234_0000;
        inst_req_i = 1'b1; inst_addr_i = 32'h0040_0010;
        tick();
        checks++; if ({bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o} !== {1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'h1234_0000}) begin
            errs++; $display("FAIL prio_data_first: got req=%b wr=%b sz=%0d addr=%h wd=%h want 1 1 1 80000002 12340000", bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o); end
        tick();
        tick();
        checks++; if ({data_valid_o, inst_valid_o, stall_o} !== 3'b101) begin errs++; $display("FAIL prio_c3: got dv,iv,stall=%b want 101", {data_valid_o, inst_valid_o, stall_o}); end
        tick();
        data_req_i = 1'b0;
        checks++; if ({bus_req_o, bus_wr_o, bus_addr_o, data_valid_o} !== {1'b1, 1'b0, 32'h0040_0010, 1'b0}) begin
            errs++; $display("FAIL prio_fetch_issue: got req=%b wr=%b addr=%h dv=%b want 1 0 00400010 0", bus_req_o, bus_wr_o, bus_addr_o, data_valid_o); end
        tick();
        tick();
        checks++; if (inst_valid_o !== 1'b1 || inst_rdata_o !== rd(32'h0040_0010)) begin
            errs++; $display("FAIL prio_fetch_ret: got v=%b d=%h want 1 %h", inst_valid_o, inst_rdata_o, rd(32'h0040_0010)); end
        tick();
        inst_req_i = 1'b0;
        tick();
    endtask

    task automatic test_addr_delay();
        a_dly = 4;
        inst_addr_i = 32'h0040_0100; inst_req_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++; if (inst_valid_o !== 1'b0) begin errs++; $display("FAIL adly_early_valid c%0d: got 1 want 0", c); end
            if (c <= 5) begin
                checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0040_0100) begin
                    errs++; $display("FAIL adly_stable c%0d: got req=%b addr=%h want 1 00400100", c, bus_req_o, bus_addr_o); end
            end else begin
                checks++; if (bus_req_o !== 1'b0) begin errs++; $display("FAIL adly_wait_req: got 1 want 0"); end
            end
        end
        tick();
        checks++; if (inst_valid_o !== 1'b1 || inst_rdata_o !== rd(32'h0040_0100)) begin
            errs++; $display("FAIL adly_c7: got v=%b d=%h want 1 %h", inst_valid_o, inst_rdata_o, rd(32'h0040_0100)); end
        tick();
        inst_req_i = 1'b0; a_dly = 0;
        tick();
    endtask

    task automatic test_flush();
        int n0;
        n0 = bus_log.size();
        d_dly = 2;
        inst_addr_i = 32'h0040_0200; inst_req_i = 1'b1;
        tick();
        tick();
        flush_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL flush_stall: got %b want 0", stall_o); end
        tick();
        flush_i = 1'b0; inst_addr_i = 32'h0080_0000;
        tick();
        d_dly = 0;
        tick();
        checks++; if (inst_valid_o !== 1'b0 || inst_rdata_o !== rd(32'h0040_0100)) begin
            errs++; $display("FAIL flush_drop: got v=%b d=%h want 0 %h", inst_valid_o, inst_rdata_o, rd(32'h0040_0100)); end
        checks++; if (bus_log.size() != n0 + 1) begin errs++; $display("FAIL flush_completes: got txns=%0d want 1", bus_log.size() - n0); end
        tick();
        checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0080_0000) begin
            errs++; $display("FAIL flush_next_issue: got req=%b addr=%h want 1 00800000", bus_req_o, bus_addr_o); end
        tick();
        tick();
        checks++; if (inst_valid_o !== 1'b1 || inst_rdata_o !== rd(32'h0080_0000)) begin
            errs++; $display("FAIL flush_next_ret: got v=%b d=%h want 1 %h", inst_valid_o, inst_rdata_o, rd(32'h0080_0000)); end
        tick();
        inst_req_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n0;
        int k;
        n0 = bus_log.size();
        data_req_i = 1'b1; data_wr_i = 1'b0; data_sel_i = 4'b1111; data_addr_i = 32'h1000_0004;
        k = 0;
        while (k < 20 && !data_valid_o) begin tick(); k++; end
        checks++; if (data_valid_o !== 1'b1 || k != 3 || data_rdata_o !== rd(32'h1000_0004)) begin
            errs++; $display("FAIL b2b_first: got v=%b lat=%0d d=%h want 1 3 %h", data_valid_o, k, data_rdata_o, rd(32'h1000_0004)); end
        tick();
        data_sel_i = 4'b0001; data_addr_i = 32'h1000_0009;
        k = 0;
        while (k < 20 && !data_valid_o) begin tick(); k++; end
        checks++; if (data_valid_o !== 1'b1 || k != 3 || data_rdata_o !== rd(32'h1000_0009)) begin
            errs++; $display("FAIL b2b_second: got v=%b lat=%0d d=%h want 1 3 %h", data_valid_o, k, data_rdata_o, rd(32'h1000_0009)); end
        tick();
        data_req_i = 1'b0;
        repeat (3) tick();
        checks++; if (bus_log.size() != n0 + 2) begin errs++; $display("FAIL b2b_txn_count: got %0d want 2", bus_log.size() - n0); end
        else begin
            checks++; if (bus_log[n0 + 1].size !== 2'd0 || bus_log[n0].size !== 2'd2) begin
                errs++; $display("FAIL b2b_sizes: got %0d,%0d want 2,0", bus_log[n0].size, bus_log[n0 + 1].size); end
        end
    endtask

    task automatic test_reset_in_wait();
        d_dly = 3;
        inst_addr_i = 32'h0040_0300; inst_req_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0; inst_req_i = 1'b0;
        tick();
        checks++; if ({bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o} !== 68'h0) begin
            errs++; $display("FAIL rstw_bus: got req=%b wr=%b sz=%0d addr=%h wd=%h want all 0", bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o); end
        checks++; if ({inst_rdata_o, data_rdata_o, inst_valid_o, data_valid_o} !== 66'h0) begin
            errs++; $display("FAIL rstw_ret: got id=%h dd=%h iv=%b dv=%b want all 0", inst_rdata_o, data_rdata_o, inst_valid_o, data_valid_o); end
        tick();
        rst_i = 1'b1; d_dly = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if ({inst_valid_o, bus_req_o} !== 2'b00) begin errs++; $display("FAIL rstw_quiet c%0d: got %b want 00", c, {inst_valid_o, bus_req_o}); end
        end
    endtask

    task automatic test_random();
        int n0;
        n0 = bus_log.size();
        rand_dly = 1'b1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    logic [31:0] a;
                    int k;
                    a = $urandom & 32'hFFFF_FFFC;
                    inst_addr_i = a; inst_req_i = 1'b1;
                    k = 0;
                    while (k < 60 && !inst_valid_o) begin tick(); k++; end
                    checks++;
                    if (inst_valid_o !== 1'b1) begin errs++; $display("FAIL rnd_inst_timeout %0d: got no valid want valid", i); end
                    else if (inst_rdata_o !== rd(a) || k < 3) begin errs++; $display("FAIL rnd_inst_data %0d: got %h lat=%0d want %h lat>=3", i, inst_rdata_o, k, rd(a)); end
                    checks++; if (bus_log[bus_log.size() - 1] !== {a, 1'b0, 2'd2, 32'h0}) begin
                        errs++; $display("FAIL rnd_inst_bus %0d: got %h want %h", i, bus_log[bus_log.size() - 1], {a, 1'b0, 2'd2, 32'h0}); end
                    tick();
                    inst_req_i = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    logic [31:0] a, wd;
                    logic [3:0] sel;
                    logic wr;
                    int k;
                    a = $urandom; wd = $urandom; sel = 4'($urandom); wr = 1'($urandom);
                    data_addr_i = a; data_wdata_i = wd; data_sel_i = sel; data_wr_i = wr; data_req_i = 1'b1;
                    k = 0;
                    while (k < 60 && !data_valid_o) begin tick(); k++; end
                    checks++;
                    if (data_valid_o !== 1'b1) begin errs++; $display("FAIL rnd_data_timeout %0d: got no valid want valid", i); end
                    else if ((!wr && data_rdata_o !== rd(a)) || k < 3) begin errs++; $display("FAIL rnd_data_load %0d: got %h lat=%0d want %h lat>=3", i, data_rdata_o, k, rd(a)); end
                    checks++; if (bus_log[bus_log.size() - 1].addr !== a || bus_log[bus_log.size() - 1].wr !== wr ||
                                  bus_log[bus_log.size() - 1].size !== exp_size(sel) || (wr && bus_log[bus_log.size() - 1].wdata !== wd)) begin
                        errs++; $display("FAIL rnd_data_bus %0d: got %h want addr=%h wr=%b sz=%0d wd=%h", i, bus_log[bus_log.size() - 1], a, wr, exp_size(sel), wd); end
                    tick();
                    data_req_i = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        join
        repeat (4) tick();
        rand_dly = 1'b0;
        checks++; if (bus_log.size() != n0 + 50) begin errs++; $display("FAIL rnd_txn_count: got %0d want 50", bus_log.size() - n0); end
    endtask

    initial begin
        rst_i = 1'b0; inst_req_i = 1'b0; inst_addr_i = '0; flush_i = 1'b0;
        data_req_i = 1'b0; data_wr_i = 1'b0; data_sel_i = '0; data_addr_i = '0; data_wdata_i = '0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_addr_delay();
        test_flush();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
